alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Registered issue/retire controller that sits directly upstream of `ALU_nbit`, drives its `A`, `B`, `Mode` and `CB_in` ports, and captures `Result`/`CB_out` into an output register. It accepts one operation per valid/ready transaction and returns the result with carry and zero flags over a second valid/ready handshake. It keeps a carry/borrow flag across operations so that multi-word add/subtract chains can be run without external glue.

## Interface
- `N`, default 3: ALU width parameter; passed as `n` to the attached `ALU_nbit`; all data paths are N+1 bits ([N:0]).

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  controller can accept a request
- `in_mode`  in  3  ALU mode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 INC, 111 DEC)
- `in_a`, `in_b`  in  N+1  operands
- `in_cb`  in  1  explicit carry/borrow-in
- `in_use_cf`  in  1  1: drive `alu_cb_in` from stored `cf`; 0: from `in_cb`
- `cf_clr`  in  1  synchronous clear of `cf`
- `alu_a`, `alu_b`  out  N+1  to ALU `A`, `B` (registered)
- `alu_mode`  out  3  to ALU `Mode` (registered)
- `alu_cb_in`  out  1  to ALU `CB_in` (registered)
- `alu_result`  in  N+1  from ALU `Result`
- `alu_cb_out`  in  1  from ALU `CB_out`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_result`  out  N+1  captured result
- `out_cb`  out  1  captured `CB_out`
- `out_zero`  out  1  1 when `out_result` == 0
- `out_mode`  out  3  mode of the retired operation
- `cf`  out  1  stored carry/borrow flag

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: `in_ready`=1. On `in_valid`: load `alu_a`←`in_a`, `alu_b`←`in_b`, `alu_mode`←`in_mode`, `alu_cb_in`←(`in_use_cf` ? `cf` : `in_cb`), then go to EXEC.
- EXEC (exactly one cycle, the ALU settling cycle): `in_ready`=0. At the end of the cycle, capture `out_result`←`alu_result`, `out_cb`←`alu_cb_out`, `out_zero`←(`alu_result`==0), `out_mode`←`alu_mode`, then go to DONE.
- DONE: `out_valid`=1; all `out_*` held stable while `out_ready`=0.
  - `out_ready`=1 and `in_valid`=0: go to IDLE.
  - `out_ready`=1 and `in_valid`=1: accept the new request (load as in IDLE) and go to EXEC.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`). This is combinational from the state and `out_ready`.
- `cf` update happens on the EXEC→DONE edge, and only for modes 000, 001, 110, 111: `cf`←`alu_cb_out`. Logic modes (010–101) leave `cf` unchanged.
- `cf_clr` forces `cf`=0 on the next edge and takes priority over a coincident update.
- `alu_b` is loaded even for unary modes; the ALU ignores it.
- `alu_*` registers hold their last value outside EXEC. They are not cleared after retire.
- Width: no arithmetic is done here; results are N+1 bits, passed through unmodified.

## Timing
- Reset values: state IDLE; `alu_a`, `alu_b`, `alu_mode`, `alu_cb_in`, `out_result`, `out_cb`, `out_mode`, `cf` = 0; `out_valid`=0; `out_zero`=0; `in_ready`=1 once in IDLE.
- Request accepted at edge k → `alu_*` valid after k → result sampled at edge k+1 → `out_valid`=1 after k+1. Latency is 2 edges.
- Throughput is one operation per 2 cycles with `out_ready` held at 1.
- `rst` asserted in any state: takes effect immediately (asynchronous). It discards the in-flight operation, drops `out_valid` without a handshake, and clears `cf`.
- A request presented while `in_ready`=0 is not consumed; the requester holds it.

## Test plan
- ADD, `in_a`=4, `in_b`=2, `in_cb`=1, `in_use_cf`=0 → `alu_cb_in`=1; `out_result`=0111, `out_cb`=0, `out_zero`=0, `cf`=0, with `out_valid` 2 edges after accept.
- Carry chain: ADD 8+14, `in_cb`=0 → `out_result`=0110, `out_cb`=1, `cf`=1. Then ADD 1+1 with `in_use_cf`=1 → `alu_cb_in`=1, `out_result`=0011, `cf`=0.
- Flag preservation: with `cf`=1, AND 5&12 → `out_result`=0100 and `cf` stays 1. XOR 5^5 → `out_result`=0000, `out_zero`=1. Then `cf_clr` asserted together with an arithmetic retire → `cf`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0. Then raise `out_ready` and `in_valid` in the same cycle → new request accepted that edge, next `out_valid` after 2 more edges.
- Reset mid-operation: assert `rst` during EXEC of DEC A=11 → `out_valid`=0 and `cf`=0 immediately, no result retired. After release, INC A=5 → `out_result`=0110.
- Mode sweep of all 8 modes on A=8, B=14 (NOT/INC/DEC on A only), compared against an `ALU_nbit #(.n(3))` reference model; `out_mode` matches each request.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller in front of ALU_nbit: registers one operation into the ALU,
// captures its result one settling cycle later, and keeps a carry/borrow flag for chains.
module alu_issue_ctrl #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_mode,
    input  logic [N:0]   in_a,
    input  logic [N:0]   in_b,
    input  logic         in_cb,
    input  logic         in_use_cf,
    input  logic         cf_clr,
    output logic [N:0]   alu_a,
    output logic [N:0]   alu_b,
    output logic [2:0]   alu_mode,
    output logic         alu_cb_in,
    input  logic [N:0]   alu_result,
    input  logic         alu_cb_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out_result,
    output logic         out_cb,
    output logic         out_zero,
    output logic [2:0]   out_mode,
    output logic         cf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] MODE_ADD = 3'b000;
    localparam logic [2:0] MODE_SUB = 3'b001;
    localparam logic [2:0] MODE_INC = 3'b110;
    localparam logic [2:0] MODE_DEC = 3'b111;

    state_t state;
    logic   accept;
    logic   retire;

    // Only the arithmetic modes produce a meaningful carry/borrow worth chaining.
    function automatic logic is_arith(input logic [2:0] mode);
        return (mode == MODE_ADD) || (mode == MODE_SUB) ||
               (mode == MODE_INC) || (mode == MODE_DEC);
    endfunction

    function automatic logic is_zero(input logic [N:0] value);
        return (value == '0);
    endfunction

    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign retire   = (state == DONE) & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_mode   <= '0;
            alu_cb_in  <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_cb     <= 1'b0;
            out_zero   <= 1'b0;
            out_mode   <= '0;
            cf         <= 1'b0;
        end else begin
            // Issue: operands go straight to the ALU inputs; they stay put until the next accept.
            if (accept) begin
                alu_a     <= in_a;
                alu_b     <= in_b;
                alu_mode  <= in_mode;
                alu_cb_in <= in_use_cf ? cf : in_cb;
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    out_result <= alu_result;
                    out_cb     <= alu_cb_out;
                    out_zero   <= is_zero(alu_result);
                    out_mode   <= alu_mode;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (retire) begin
                        out_valid <= 1'b0;
                        state     <= in_valid ? EXEC : IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase

            // A clear wins over a carry update landing on the same edge.
            if (cf_clr) begin
                cf <= 1'b0;
            end else if ((state == EXEC) && is_arith(alu_mode)) begin
                cf <= alu_cb_out;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: models the attached ALU_nbit, runs directed table vectors,
// hand-written corner sequences, and random operations against a reference model.
module tb_alu_issue_ctrl;

    localparam int N = 3;
    localparam int W = N + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_mode;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cb;
    logic         in_use_cf;
    logic         cf_clr;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_mode;
    logic         alu_cb_in;
    logic [W-1:0] alu_result;
    logic         alu_cb_out;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_cb;
    logic         out_zero;
    logic [2:0]   out_mode;
    logic         cf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b), .in_cb(in_cb), .in_use_cf(in_use_cf), .cf_clr(cf_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_cb_in(alu_cb_in),
        .alu_result(alu_result), .alu_cb_out(alu_cb_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_cb(out_cb), .out_zero(out_zero), .out_mode(out_mode), .cf(cf)
    );

    // ALU_nbit #(.n(3)) behaviour: returns {carry/borrow, result}
    function automatic logic [W:0] alu_ref(input logic [2:0] m, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic c);
        int ai, bi, ci, full;
        logic [W-1:0] res;
        logic co;
        ai = int'(a); bi = int'(b); ci = int'(c);
        co = 1'b0;
        case (m)
            3'd0: begin full = ai + bi + ci; co = (full >= (1 << W)); res = W'(full % (1 << W)); end
            3'd1: begin full = ai - bi - ci; co = (full < 0); res = W'((full + 2 * (1 << W)) % (1 << W)); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = ~a;
            3'd6: begin full = ai + 1; co = (full >= (1 << W)); res = W'(full % (1 << W)); end
            default: begin full = ai - 1; co = (full < 0); res = W'((full + (1 << W)) % (1 << W)); end
        endcase
        return {co, res};
    endfunction

    always_comb begin
        {alu_cb_out, alu_result} = alu_ref(alu_mode, alu_a, alu_b, alu_cb_in);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Full transaction from IDLE; entered and left on a falling edge with out_ready low.
    task automatic run_op(input string tag, input logic [2:0] m, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c, input logic uc,
                          input logic [W-1:0] er, input logic ecb, input logic ez,
                          input logic ecf, input logic ecbin, input int hold);
        in_mode = m; in_a = a; in_b = b; in_cb = c; in_use_cf = uc; in_valid = 1'b1;
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " alu_a"}, 32'(alu_a), 32'(a));
        check({tag, " alu_b"}, 32'(alu_b), 32'(b));
        check({tag, " alu_mode"}, 32'(alu_mode), 32'(m));
        check({tag, " alu_cb_in"}, 32'(alu_cb_in), 32'(ecbin));
        check({tag, " exec out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " exec in_ready"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            check({tag, " out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " out_result"}, 32'(out_result), 32'(er));
            check({tag, " out_cb"}, 32'(out_cb), 32'(ecb));
            check({tag, " out_zero"}, 32'(out_zero), 32'(ez));
            check({tag, " out_mode"}, 32'(out_mode), 32'(m));
            check({tag, " cf"}, 32'(cf), 32'(ecf));
            check({tag, " done in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " retired out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " retired in_ready"}, 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        string        name;
        logic [2:0]   mode;
        logic [W-1:0] a, b;
        logic         cb, use_cf;
        logic [W-1:0] res;
        logic         cbo, zero, cfv, cbin;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0]   ref_out;
        logic [2:0]   m;
        logic [W-1:0] a, b;
        logic         c, uc, mcf, cbin;
        logic [W-1:0] held;

        rst = 1'b1; in_valid = 1'b0; in_mode = '0; in_a = '0; in_b = '0;
        in_cb = 1'b0; in_use_cf = 1'b0; cf_clr = 1'b0; out_ready = 1'b0;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst cf", 32'(cf), 32'd0);
        check("rst alu_a", 32'(alu_a), 32'd0);
        check("rst alu_cb_in", 32'(alu_cb_in), 32'd0);
        check("rst out_result", 32'(out_result), 32'd0);
        check("rst out_zero", 32'(out_zero), 32'd0);
        check("rst out_mode", 32'(out_mode), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        //            name       mode  a   b   cb uc  res cbo z  cf cbin
        vecs.push_back('{"add4_2",   3'd0, 4,  2,  1, 0,  7,  0, 0, 0, 1});
        vecs.push_back('{"add8_14",  3'd0, 8,  14, 0, 0,  6,  1, 0, 1, 0});
        vecs.push_back('{"add1_1cf", 3'd0, 1,  1,  0, 1,  3,  0, 0, 0, 1});
        vecs.push_back('{"setcf",    3'd0, 8,  14, 0, 0,  6,  1, 0, 1, 0});
        vecs.push_back('{"and5_12",  3'd2, 5,  12, 0, 0,  4,  0, 0, 1, 0});
        vecs.push_back('{"xor5_5",   3'd4, 5,  5,  0, 0,  0,  0, 1, 1, 0});
        vecs.push_back('{"sw_add",   3'd0, 8,  14, 0, 0,  6,  1, 0, 1, 0});
        vecs.push_back('{"sw_sub",   3'd1, 8,  14, 0, 0,  10, 1, 0, 1, 0});
        vecs.push_back('{"sw_and",   3'd2, 8,  14, 0, 0,  8,  0, 0, 1, 0});
        vecs.push_back('{"sw_or",    3'd3, 8,  14, 0, 0,  14, 0, 0, 1, 0});
        vecs.push_back('{"sw_xor",   3'd4, 8,  14, 0, 0,  6,  0, 0, 1, 0});
        vecs.push_back('{"sw_not",   3'd5, 8,  14, 0, 0,  7,  0, 0, 1, 0});
        vecs.push_back('{"sw_inc",   3'd6, 8,  14, 0, 0,  9,  0, 0, 0, 0});
        vecs.push_back('{"sw_dec",   3'd7, 8,  14, 0, 0,  7,  0, 0, 0, 0});

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cb,
                   vecs[i].use_cf, vecs[i].res, vecs[i].cbo, vecs[i].zero,
                   vecs[i].cfv, vecs[i].cbin, 0);
        end

        // cf_clr coincident with an arithmetic retire that would otherwise set cf
        run_op("pre_clr", 3'd0, 8, 14, 0, 0, 6, 1, 0, 1, 0, 0);
        in_mode = 3'd0; in_a = 15; in_b = 0; in_cb = 1'b1; in_use_cf = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cf_clr = 1'b1;
        @(negedge clk);
        cf_clr = 1'b0;
        check("clr out_cb", 32'(out_cb), 32'd1);
        check("clr out_zero", 32'(out_zero), 32'd1);
        check("clr cf", 32'(cf), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Backpressure, then retire and accept on the same edge
        in_mode = 3'd3; in_a = 3; in_b = 4; in_cb = 1'b0; in_use_cf = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp out_result", 32'(out_result), 32'd7);
            check("bp in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_mode = 3'd1; in_a = 5; in_b = 3; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp in_ready on ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b out_valid", 32'(out_valid), 32'd0);
        check("b2b alu_mode", 32'(alu_mode), 32'd1);
        check("b2b alu_a", 32'(alu_a), 32'd5);
        @(negedge clk);
        check("b2b valid", 32'(out_valid), 32'd1);
        check("b2b result", 32'(out_result), 32'd2);
        check("b2b out_mode", 32'(out_mode), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during EXEC of DEC 11 with cf set
        run_op("pre_rst", 3'd0, 8, 14, 0, 0, 6, 1, 0, 1, 0, 0);
        in_mode = 3'd7; in_a = 11; in_b = 0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst exec out_valid", 32'(out_valid), 32'd0);
        check("rst exec cf", 32'(cf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst no retire", 32'(out_valid), 32'd0);

        // Reset while a result is waiting in DONE
        in_mode = 3'd2; in_a = 15; in_b = 15; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre rst done valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst done out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("inc5", 3'd6, 5, 0, 0, 0, 6, 0, 0, 0, 0, 0);

        // Random operations against the reference model
        mcf = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                cf_clr = 1'b1;
                @(negedge clk);
                cf_clr = 1'b0;
                mcf = 1'b0;
                check("rnd cf_clr", 32'(cf), 32'd0);
            end
            m = 3'($urandom_range(0, 7));
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            uc = 1'($urandom);
            cbin = uc ? mcf : c;
            ref_out = alu_ref(m, a, b, cbin);
            if (m == 3'd0 || m == 3'd1 || m == 3'd6 || m == 3'd7) mcf = ref_out[W];
            held = ref_out[W-1:0];
            run_op($sformatf("rnd%0d", t), m, a, b, c, uc, held, ref_out[W],
                   (held == '0), mcf, cbin, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
